// File: rtl/vga_pattern_sequencer.sv
// KEYA push-button front end for the VGA test-pattern path: synchronise, debounce,
// classify short/long presses, and switch patterns only on frame boundaries.
module vga_pattern_sequencer #(
  parameter int unsigned DEB_CYCLES  = 1000000,
  parameter int unsigned LONG_CYCLES = 50000000,
  parameter int unsigned NUM_PAT     = 8,
  parameter int unsigned AUTO_FRAMES = 60
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       keya_i,
  input  logic       frame_start_i,
  output logic [2:0] pat_sel_o,
  output logic       auto_mode_o,
  output logic       pat_update_o,
  output logic       key_press_o
);

  localparam int unsigned DW = $clog2(DEB_CYCLES) + 1;
  localparam int unsigned HW = $clog2(LONG_CYCLES) + 1;
  localparam int unsigned FW = $clog2(AUTO_FRAMES) + 1;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [DW-1:0] DEB_INC   = DW'(1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_INC  = HW'(1);
  localparam logic [FW-1:0] AUTO_LAST = FW'(AUTO_FRAMES - 1);
  localparam logic [FW-1:0] FRAME_INC = FW'(1);
  localparam logic [2:0]    PAT_LAST  = 3'(NUM_PAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } key_state_e;

  logic          sync1_q, sync2_q;
  logic          key_db_q, key_db_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  key_state_e    state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          short_s, toggle_s;
  logic          pending_q, pending_d;
  logic          auto_mode_q, auto_mode_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [2:0]    pat_sel_q, pat_sel_d;
  logic          pat_update_q, pat_update_d;
  logic          key_press_q;
  logic          advance_s;
  logic [2:0]    pat_next_s;

  // Debounce: the accepted level follows the synced level only after a full run of disagreement.
  always_comb begin
    key_db_d  = key_db_q;
    deb_cnt_d = '0;
    if (sync2_q != key_db_q) begin
      if (deb_cnt_q >= DEB_LAST) begin
        key_db_d  = sync2_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_INC;
      end
    end else begin
      deb_cnt_d = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    short_s    = 1'b0;
    toggle_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!key_db_q) begin
          state_d    = ST_PRESSED;
          hold_cnt_d = '0;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_PRESSED: begin
        // Release wins over the long-press threshold when both land in the same cycle.
        if (key_db_q) begin
          short_s = 1'b1;
          state_d = ST_IDLE;
        end else if (hold_cnt_q >= LONG_LAST) begin
          toggle_s = 1'b1;
          state_d  = ST_HELD;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_INC;
        end
      end
      ST_HELD: begin
        if (key_db_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HELD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    advance_s  = frame_start_i &&
                 (pending_q || (auto_mode_q && (frame_cnt_q == AUTO_LAST)));
    pat_next_s = (pat_sel_q >= PAT_LAST) ? 3'd0 : (pat_sel_q + 3'd1);
    pat_sel_d    = advance_s ? pat_next_s : pat_sel_q;
    pat_update_d = advance_s;
    auto_mode_d  = toggle_s ? ~auto_mode_q : auto_mode_q;

    // A press decided in the same cycle as FRAME_START survives to the next frame.
    if (short_s) begin
      pending_d = 1'b1;
    end else if (advance_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    if (toggle_s || !auto_mode_q) begin
      frame_cnt_d = '0;
    end else if (frame_start_i) begin
      frame_cnt_d = advance_s ? '0 : (frame_cnt_q + FRAME_INC);
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      key_db_q     <= 1'b1;
      deb_cnt_q    <= '0;
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
      pending_q    <= 1'b0;
      auto_mode_q  <= 1'b0;
      frame_cnt_q  <= '0;
      pat_sel_q    <= 3'd0;
      pat_update_q <= 1'b0;
      key_press_q  <= 1'b0;
    end else begin
      sync1_q      <= keya_i;
      sync2_q      <= sync1_q;
      key_db_q     <= key_db_d;
      deb_cnt_q    <= deb_cnt_d;
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      pending_q    <= pending_d;
      auto_mode_q  <= auto_mode_d;
      frame_cnt_q  <= frame_cnt_d;
      pat_sel_q    <= pat_sel_d;
      pat_update_q <= pat_update_d;
      key_press_q  <= short_s;
    end
  end

  assign pat_sel_o    = pat_sel_q;
  assign auto_mode_o  = auto_mode_q;
  assign pat_update_o = pat_update_q;
  assign key_press_o  = key_press_q;

endmodule
